// File: rtl/pt_dec.sv
`timescale 1ns/1ps
// pt_dec: decodes a PT2262-style serial waveform into 24-bit code words.
//
// The raw line is synchronised, then high and low runs are measured in clock
// cycles and classified as short (1..2U-1), long (2U..4U) or over (>4U).
// A (long,short) pair is a 1, a (short,long) pair a 0, and a short high
// followed by a low of at least SYNC_MIN units is the sync that closes a
// 24-bit frame (sent MSB first).
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   q     - raw encoded line, asynchronous, idles low
//   data  - last accepted code word, first received bit in data[23]
//   valid - one-cycle pulse, data updated this cycle
//   err   - one-cycle pulse, frame aborted on illegal width or sequence
//
// SYNC_MIN must exceed 4 so that an over-length low is distinguishable from
// a sync gap.
module pt_dec #(
  parameter int UNIT     = 4,
  parameter int SYNC_MIN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        q,
  output logic [23:0] data,
  output logic        valid,
  output logic        err
);

  localparam int CMAX = SYNC_MIN * UNIT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_SYNC      = CW'(CMAX);
  localparam logic [CW-1:0] C_SHORT_MAX = CW'(2 * UNIT - 1);
  localparam logic [CW-1:0] C_LONG_MAX  = CW'(4 * UNIT);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  logic          s1;
  logic          s;
  logic          s_d;
  logic          rise;
  logic          fall;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] lcnt;
  logic [1:0]    state;
  logic [23:0]   sr;
  logic [4:0]    bc;
  logic          h_short;
  logic          h_long;
  logic          l_short;
  logic          l_long;

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_comb begin
    h_short = (hcnt != '0) && (hcnt <= C_SHORT_MAX);
    h_long  = (hcnt > C_SHORT_MAX) && (hcnt <= C_LONG_MAX);
    l_short = (lcnt != '0) && (lcnt <= C_SHORT_MAX);
    l_long  = (lcnt > C_SHORT_MAX) && (lcnt <= C_LONG_MAX);
  end

  // Synchroniser and run counters. hcnt holds the last high length while the
  // line is low, so the pair can be classified on the following rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
      hcnt <= '0;
      lcnt <= '0;
    end else begin
      s1  <= q;
      s   <= s1;
      s_d <= s;
      if (s) begin
        if (rise)
          hcnt <= C_ONE;
        else if (hcnt != C_SYNC)
          hcnt <= hcnt + C_ONE;
        lcnt <= '0;
      end else begin
        if (fall)
          lcnt <= C_ONE;
        else if (lcnt != C_SYNC)
          lcnt <= lcnt + C_ONE;
      end
    end
  end

  // A sync gap that completes in the same cycle as the next rising edge goes
  // straight to HIGH instead of via GAP, so that edge is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HUNT;
      sr    <= '0;
      bc    <= '0;
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (lcnt == C_SYNC) begin
            if (rise) begin
              state <= ST_HIGH;
              bc    <= '0;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (rise) begin
            state <= ST_HIGH;
            bc    <= '0;
          end
        end
        ST_HIGH: begin
          if (hcnt > C_LONG_MAX) begin
            err   <= 1'b1;
            state <= ST_HUNT;
          end else if (fall) begin
            state <= ST_LOW;
          end
        end
        default: begin // ST_LOW
          if (bc != 5'd24) begin
            if (lcnt > C_LONG_MAX) begin
              err   <= 1'b1;
              state <= ST_HUNT;
            end else if (rise) begin
              if (h_long && l_short) begin
                sr    <= {sr[22:0], 1'b1};
                bc    <= bc + 5'd1;
                state <= ST_HIGH;
              end else if (h_short && l_long) begin
                sr    <= {sr[22:0], 1'b0};
                bc    <= bc + 5'd1;
                state <= ST_HIGH;
              end else begin
                err   <= 1'b1;
                state <= ST_HUNT;
              end
            end
          end else begin
            if (!h_short) begin
              err   <= 1'b1;
              state <= ST_HUNT;
            end else if (lcnt == C_SYNC) begin
              data  <= sr;
              valid <= 1'b1;
              if (rise) begin
                state <= ST_HIGH;
                bc    <= '0;
              end else begin
                state <= ST_GAP;
              end
            end else if (rise) begin
              err   <= 1'b1;
              state <= ST_HUNT;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt_dec.sv
`timescale 1ns/1ps
module tb_pt_dec;

  localparam int U  = 4;
  localparam int SM = 16;

  logic        clk;
  logic        rst;
  logic        q;
  logic [23:0] data;
  logic        valid;
  logic        err;

  pt_dec #(.UNIT(U), .SYNC_MIN(SM)) dut (
    .clk   (clk),
    .rst   (rst),
    .q     (q),
    .data  (data),
    .valid (valid),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcnt   = 0;
  int ecnt   = 0;
  int both   = 0;
  int last_vcyc = -1;
  int t0     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcnt = vcnt + 1;
      last_vcyc = cyc;
    end
    if (err) ecnt = ecnt + 1;
    if (valid && err) both = both + 1;
  end

  typedef struct {
    logic [23:0] word;
    int          bad_bit;
    int          nbits;
    int          exp_v;
    logic [23:0] exp_data;
    int          exp_e;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int cycles);
    q = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      drive(1'b1, 3*U);
      drive(1'b0, 1*U);
    end else begin
      drive(1'b1, 1*U);
      drive(1'b0, 3*U);
    end
  endtask

  // Bits first..last (MSB-first position); position bad gets a 6-unit high.
  task automatic send_bits(input logic [23:0] w, input int first, input int last, input int bad);
    for (int i = first; i <= last; i++) begin
      if (i == bad) begin
        drive(1'b1, 6*U);
        drive(1'b0, 2*U);
      end else begin
        send_bit(w[23-i]);
      end
    end
  endtask

  task automatic send_sync();
    drive(1'b1, U);
    t0 = cyc + 1;
    drive(1'b0, 31*U);
  endtask

  int v0, e0;
  int vc[4];

  initial begin
    vecs[0] = '{24'hAAAA01, -1, 24, 1, 24'hAAAA01, 0};
    vecs[1] = '{24'h000000, -1, 24, 1, 24'h000000, 0};
    vecs[2] = '{24'hFFFFFF, -1, 24, 1, 24'hFFFFFF, 0};
    vecs[3] = '{24'h5A5A5A, -1, 24, 1, 24'h5A5A5A, 0};
    vecs[4] = '{24'h3C3C3C,  5, 24, 0, 24'h5A5A5A, 1};
    vecs[5] = '{24'hA5A5A5, -1, 24, 1, 24'hA5A5A5, 0};
    vecs[6] = '{24'h7FFFFF, -1, 23, 0, 24'hA5A5A5, 1};
    vecs[7] = '{24'h123456, -1, 24, 1, 24'h123456, 0};

    rst = 1'b1;
    q   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data",  {8'h0, data}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_err",   {31'h0, err}, 32'h0);
    rst = 1'b0;
    drive(1'b0, 80);

    for (int i = 0; i < 8; i++) begin
      v0 = vcnt;
      e0 = ecnt;
      send_bits(vecs[i].word, 0, vecs[i].nbits - 1, vecs[i].bad_bit);
      send_sync();
      check($sformatf("vec%0d_valid", i), vcnt - v0, vecs[i].exp_v);
      check($sformatf("vec%0d_err", i),   ecnt - e0, vecs[i].exp_e);
      check($sformatf("vec%0d_data", i),  {8'h0, data}, {8'h0, vecs[i].exp_data});
      if (i < 4) vc[i] = last_vcyc;
      if (i == 0) check("frame_latency", last_vcyc, t0 + SM*U + 2);
    end
    check("spacing_1_2", vc[2] - vc[1], 512);
    check("spacing_2_3", vc[3] - vc[2], 512);

    // Reset in the middle of a frame.
    send_bits(24'hABCDEF, 0, 23, -1);
    send_sync();
    check("pre_rst_data", {8'h0, data}, 32'hABCDEF);
    send_bits(24'h111111, 0, 9, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_data",  {8'h0, data}, 32'h0);
    check("rst_mid_valid", {31'h0, valid}, 32'h0);
    v0 = vcnt;
    e0 = ecnt;
    send_bits(24'h111111, 10, 23, -1);
    send_sync();
    check("rst_tail_valid", vcnt - v0, 0);
    check("rst_tail_err",   ecnt - e0, 0);
    v0 = vcnt;
    send_bits(24'h0F1E2D, 0, 23, -1);
    send_sync();
    check("post_rst_valid", vcnt - v0, 1);
    check("post_rst_data",  {8'h0, data}, 32'h0F1E2D);

    // Line stuck high, long low, then a clean frame.
    v0 = vcnt;
    e0 = ecnt;
    drive(1'b1, 100);
    drive(1'b0, 40*U);
    check("stuck_hi_err_only", ecnt - e0, 1);
    send_bits(24'h0F0F0F, 0, 23, -1);
    send_sync();
    check("stuck_hi_err",   ecnt - e0, 1);
    check("stuck_hi_valid", vcnt - v0, 1);
    check("stuck_hi_data",  {8'h0, data}, 32'h0F0F0F);

    // Line stuck low: decoder stays silent.
    v0 = vcnt;
    e0 = ecnt;
    drive(1'b0, 300);
    check("stuck_lo_valid", vcnt - v0, 0);
    check("stuck_lo_err",   ecnt - e0, 0);
    check("valid_err_overlap", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
